// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX FIFO write port between
// the debug snapshot sender (0) and the dump sender (1). ARB_HEADER_EN prefixes each packet with a header byte.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT  = 16'd1000,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       wr0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       gnt0,
  input  logic       req1,
  input  logic       wr1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       gnt1,
  input  logic       fifoFull,
  output logic       fifoWrite,
  output logic [7:0] fifoData,
  output logic       busy,
  output logic       abortPulse,
  output logic       timeoutPulse
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
`ifdef ARB_HEADER_EN
    HDR,
`endif
    BUSY
  } state_t;

  state_t state, stateNext;

  logic [NUM_REQ-1:0]      req, wr, last, gnt, gntNext;
  logic [NUM_REQ-1:0][7:0] data;
  logic        own, ownNext, rrLast, rrLastNext, sel;
  logic [15:0] toCnt, toCntNext;
  logic        abortNext, timeoutNext;
  logic [7:0]  hdrByte;

  assign req  = {req1, req0};
  assign wr   = {wr1, wr0};
  assign last = {last1, last0};
  assign data = {data1, data0};

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign busy = (state != IDLE);

  // On a tie the requester that did not own the last packet wins.
  assign sel     = (req[0] & req[1]) ? ~rrLast : req[1];
  assign hdrByte = HDR_BASE | {7'd0, own};
  assign fifoData = (state == BUSY) ? data[own] : hdrByte;

  always_comb begin
    stateNext   = state;
    ownNext     = own;
    rrLastNext  = rrLast;
    gntNext     = gnt;
    toCntNext   = toCnt;
    abortNext   = 1'b0;
    timeoutNext = 1'b0;
    fifoWrite   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          ownNext   = sel;
          toCntNext = 16'd0;
`ifdef ARB_HEADER_EN
          stateNext = HDR;
`else
          stateNext = BUSY;
          gntNext   = 2'b01 << sel;
`endif
        end
      end
`ifdef ARB_HEADER_EN
      HDR: begin
        fifoWrite = ~fifoFull;
        if (!req[own]) begin
          stateNext  = IDLE;
          rrLastNext = own;
        end else if (fifoWrite) begin
          stateNext = BUSY;
          gntNext   = 2'b01 << own;
          toCntNext = 16'd0;
        end
      end
`endif
      BUSY: begin
        fifoWrite = gnt[own] & wr[own] & ~fifoFull;
        if (fifoWrite && last[own]) begin
          stateNext  = IDLE;
          gntNext    = '0;
          rrLastNext = own;
        end else if (!req[own]) begin
          stateNext  = IDLE;
          gntNext    = '0;
          rrLastNext = own;
          abortNext  = 1'b1;
        end else if (TIMEOUT != 16'd0 && toCnt == TIMEOUT) begin
          stateNext   = IDLE;
          gntNext     = '0;
          rrLastNext  = own;
          timeoutNext = 1'b1;
        end else if (fifoWrite) begin
          toCntNext = 16'd0;
        end else if (!fifoFull && toCnt != TIMEOUT) begin
          // Backpressure holds the count; only requester idling advances it.
          toCntNext = toCnt + 16'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Reset abandons any packet in flight without a final write.
    if (reset) fifoWrite = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      own          <= 1'b0;
      rrLast       <= 1'b1;
      gnt          <= '0;
      toCnt        <= 16'd0;
      abortPulse   <= 1'b0;
      timeoutPulse <= 1'b0;
    end else begin
      state        <= stateNext;
      own          <= ownNext;
      rrLast       <= rrLastNext;
      gnt          <= gntNext;
      toCnt        <= toCntNext;
      abortPulse   <= abortNext;
      timeoutPulse <= timeoutNext;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packets, round-robin, backpressure, timeout, abort, reset, header.
module tb_uart_tx_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic       req0, wr0, last0, req1, wr1, last1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, fifoFull, fifoWrite, busy, abortPulse, timeoutPulse;
  logic [7:0] fifoData;

  int checks = 0;
  int failures = 0;
  int toPulses = 0;
  logic [7:0] wq[$];

  uart_tx_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .wr0(wr0), .data0(data0), .last0(last0), .gnt0(gnt0),
    .req1(req1), .wr1(wr1), .data1(data1), .last1(last1), .gnt1(gnt1),
    .fifoFull(fifoFull), .fifoWrite(fifoWrite), .fifoData(fifoData),
    .busy(busy), .abortPulse(abortPulse), .timeoutPulse(timeoutPulse)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (fifoWrite) wq.push_back(fifoData);
    if (timeoutPulse) toPulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [7:0] d, input logic l);
    if (p == 0) begin req0 = r; wr0 = w; data0 = d; last0 = l; end
    else        begin req1 = r; wr1 = w; data1 = d; last1 = l; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; fifoFull = 1'b0;
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    cyc(2);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abortPulse, 0);
    chk("rst_tout", timeoutPulse, 0);
    chk("rst_wr", fifoWrite, 0);
    reset = 1'b0;
    cyc();
    wq.delete();

`ifdef ARB_HEADER_EN
    drive(1, 1, 1, 8'h55, 1);
    cyc();
    chk("hdr_gnt1", gnt1, 0);
    chk("hdr_wr", fifoWrite, 1);
    chk("hdr_data", fifoData, 8'hA1);
    cyc();
    chk("hdr_gnt1_busy", gnt1, 1);
    chk("hdr_payload", fifoData, 8'h55);
    cyc();
    drive(1, 0, 0, 8'h00, 0);
    chk("hdr_gnt1_done", gnt1, 0);
    cyc(2);
    chk("hdr_qn", wq.size(), 2);
    chk("hdr_q0", wq[0], 8'hA1);
    chk("hdr_q1", wq[1], 8'h55);
`else
    // single packet
    drive(0, 1, 1, 8'h11, 0);
    cyc();
    chk("sp_gnt0", gnt0, 1);
    chk("sp_busy", busy, 1);
    chk("sp_wr", fifoWrite, 1);
    chk("sp_d0", fifoData, 8'h11);
    cyc();
    drive(0, 1, 1, 8'h22, 0); #1;
    chk("sp_d1", fifoData, 8'h22);
    cyc();
    drive(0, 1, 1, 8'h33, 1);
    cyc();
    chk("sp_gnt0_fall", gnt0, 0);
    drive(0, 0, 0, 8'h00, 0);
    chk("sp_qn", wq.size(), 3);
    chk("sp_q0", wq[0], 8'h11);
    chk("sp_q1", wq[1], 8'h22);
    chk("sp_q2", wq[2], 8'h33);
    cyc();
    wq.delete();

    // tie out of a port-0-last state is not possible here; rrLast=0 now, so set it back via port 1 first
    // (tie behaviour exercised with rrLast=0 -> port 1 wins, then rrLast=1 -> port 0 wins)
    drive(1, 1, 1, 8'h50, 0);
    drive(0, 1, 0, 8'h00, 0);
    cyc();
    chk("tie_a_gnt1", gnt1, 1);
    chk("tie_a_gnt0", gnt0, 0);
    drive(0, 0, 0, 8'h00, 0);
    cyc();
    drive(1, 1, 1, 8'h51, 1);
    cyc();
    drive(1, 0, 0, 8'h00, 0);
    chk("tie_a_done", gnt1, 0);
    chk("tie_a_gap", busy, 0);
    // rrLast=1 now: port 0 must win, port 1's wr must not leak
    drive(1, 1, 1, 8'hEE, 0);
    drive(0, 1, 1, 8'h40, 0);
    cyc();
    chk("tie_b_gnt0", gnt0, 1);
    chk("tie_b_gnt1", gnt1, 0);
    chk("tie_b_d", fifoData, 8'h40);
    cyc();
    drive(0, 1, 1, 8'h41, 1);
    cyc();
    drive(0, 0, 0, 8'h00, 0);
    chk("tie_b_gap_gnt1", gnt1, 0);
    chk("tie_b_gap_busy", busy, 0);
    cyc();
    chk("tie_b_gnt1_next", gnt1, 1);
    drive(1, 1, 1, 8'h42, 1);
    cyc();
    drive(1, 0, 0, 8'h00, 0);
    chk("rr_qn", wq.size(), 5);
    chk("rr_q0", wq[0], 8'h50);
    chk("rr_q1", wq[1], 8'h51);
    chk("rr_q2", wq[2], 8'h40);
    chk("rr_q3", wq[3], 8'h41);
    chk("rr_q4", wq[4], 8'h42);
    cyc();
    // repeated tie with rrLast=1 -> port 0 wins again
    drive(0, 1, 0, 8'h00, 0);
    drive(1, 1, 0, 8'h00, 0);
    cyc();
    chk("tie_c_gnt0", gnt0, 1);
    chk("tie_c_gnt1", gnt1, 0);
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 1, 1, 8'h60, 1);
    cyc();
    drive(0, 0, 0, 8'h00, 0);
    cyc(2);
    chk("tie_c_idle", busy, 0);
    wq.delete();

    // backpressure: 2000 full cycles must not time out
    drive(0, 1, 0, 8'h00, 0);
    cyc();
    chk("bp_gnt0", gnt0, 1);
    drive(0, 1, 1, 8'h70, 0);
    fifoFull = 1'b1;
    cyc(2000);
    chk("bp_hold", gnt0, 1);
    chk("bp_nowr", wq.size(), 0);
    chk("bp_notout", toPulses, 0);
    fifoFull = 1'b0; #1;
    chk("bp_wr", fifoWrite, 1);
    cyc();
    chk("bp_once", wq.size(), 1);
    drive(0, 1, 1, 8'h71, 1);
    cyc();
    drive(0, 0, 0, 8'h00, 0);
    chk("bp_done", gnt0, 0);
    chk("bp_q0", wq[0], 8'h70);
    chk("bp_q1", wq[1], 8'h71);
    cyc();
    wq.delete();

    // timeout with port 1 pending
    drive(0, 1, 0, 8'h00, 0);
    cyc();
    chk("to_gnt0", gnt0, 1);
    drive(1, 1, 0, 8'h00, 0);
    k = 0;
    while (gnt0 && k < 1100) begin cyc(); k++; end
    chk("to_latency", k, 1001);
    chk("to_pulse", timeoutPulse, 1);
    chk("to_noabort", abortPulse, 0);
    drive(0, 0, 0, 8'h00, 0);
    cyc();
    chk("to_pulse_1cyc", timeoutPulse, 0);
    chk("to_gnt1", gnt1, 1);
    chk("to_nowr", wq.size(), 0);

    // abort: port 1 drops req after 2 of 4 bytes
    drive(1, 1, 1, 8'h80, 0);
    cyc();
    drive(1, 1, 1, 8'h81, 0);
    cyc();
    drive(1, 0, 0, 8'h00, 0);
    cyc();
    chk("ab_pulse", abortPulse, 1);
    chk("ab_gnt1", gnt1, 0);
    cyc();
    chk("ab_pulse_1cyc", abortPulse, 0);
    chk("ab_qn", wq.size(), 2);
    chk("ab_q1", wq[1], 8'h81);
    chk("to_count", toPulses, 1);
    wq.delete();

    // reset mid-packet
    drive(0, 1, 1, 8'h90, 0);
    cyc(2);
    drive(0, 1, 1, 8'h91, 0);
    reset = 1'b1;
    cyc();
    chk("rm_gnt0", gnt0, 0);
    chk("rm_busy", busy, 0);
    drive(0, 0, 0, 8'h00, 0);
    cyc();
    reset = 1'b0;
    cyc(2);
    chk("rm_qn", wq.size(), 1);
    chk("rm_q0", wq[0], 8'h90);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
